// File: rtl/ahb_master_bridge.sv
// Single-transfer AHB-Lite master for the multicycle core's memory states.
// Runs one NONSEQ word transfer per request and reports it with a done strobe.
module ahb_master_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemDone,
  output logic        MemErr,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR2,
    S_DONE
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [7:0] TMO       = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] wdata_q;

  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wdata_q  <= '0;
      HTRANS   <= TR_IDLE;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HWDATA   <= '0;
      ReadData <= '0;
      MemDone  <= 1'b0;
      MemErr   <= 1'b0;
    end else begin
      MemDone <= 1'b0;
      MemErr  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (MemReq) begin
            if (Adr[1:0] != 2'b00) begin
              state   <= S_DONE;
              MemDone <= 1'b1;
              MemErr  <= 1'b1;
            end else begin
              state   <= S_ADDR;
              HTRANS  <= TR_NONSEQ;
              HADDR   <= Adr;
              HWRITE  <= MemWrite;
              wdata_q <= WriteData;
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            state  <= S_DATA;
            HTRANS <= TR_IDLE;
            HWDATA <= HWRITE ? wdata_q : 32'h0;
            cnt    <= '0;
          end
        end
        S_DATA: begin
          if (HREADY) begin
            // a ready+error response in one cycle is treated as a failure
            if (!HRESP && !HWRITE) ReadData <= HRDATA;
            state   <= S_DONE;
            MemDone <= 1'b1;
            MemErr  <= HRESP;
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
          end else if (HRESP) begin
            state <= S_ERR2;
          end else if (cnt == TMO) begin
            state   <= S_DONE;
            MemDone <= 1'b1;
            MemErr  <= 1'b1;
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ERR2: begin
          if (HREADY) begin
            state   <= S_DONE;
            MemDone <= 1'b1;
            MemErr  <= 1'b1;
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Bench for ahb_master_bridge: directed and random transfers against
// a cycle-count model of the bus transaction.
module tb_ahb_master_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemDone;
  logic        MemErr;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_model;

  always #5 clk = ~clk;

  ahb_master_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .MemReq(MemReq),
    .MemWrite(MemWrite),
    .Adr(Adr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .MemDone(MemDone),
    .MemErr(MemErr),
    .HADDR(HADDR),
    .HWRITE(HWRITE),
    .HTRANS(HTRANS),
    .HSIZE(HSIZE),
    .HBURST(HBURST),
    .HWDATA(HWDATA),
    .HRDATA(HRDATA),
    .HREADY(HREADY),
    .HRESP(HRESP)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 ||
        HWDATA !== 32'h0 || ReadData !== 32'h0 ||
        MemDone !== 1'b0 || MemErr !== 1'b0) begin
      errors++;
      $display("FAIL %s: HTRANS=%b HADDR=%h HWRITE=%b HWDATA=%h RD=%h D=%b E=%b want all zero",
               name, HTRANS, HADDR, HWRITE, HWDATA, ReadData, MemDone, MemErr);
    end
    checks++;
    if (HSIZE !== 3'b010 || HBURST !== 3'b000) begin
      errors++;
      $display("FAIL %s_const: HSIZE=%b HBURST=%b want 010/000", name, HSIZE, HBURST);
    end
  endtask

  // mode: 0 = okay after dw data waits, 1 = error with dw extra ERR2 waits,
  // 2 = slave never ready (timeout). aw = address-phase wait states.
  task automatic run_xfer(input string name, input logic wr,
                          input logic [31:0] adr, input logic [31:0] wd,
                          input logic [31:0] rd, input int aw,
                          input int dw, input int mode);
    logic        mis;
    logic        exp_err;
    logic [31:0] exp_hw;
    int          a_end;
    int          d;
    mis   = (adr[1:0] != 2'b00);
    a_end = aw + 1;
    if (mis)            d = 1;
    else if (mode == 0) d = a_end + dw + 2;
    else if (mode == 1) d = a_end + dw + 3;
    else                d = a_end + TO + 2;
    exp_err = mis || (mode != 0);
    exp_hw  = wr ? wd : 32'h0;
    MemReq    = 1'b1;
    MemWrite  = wr;
    Adr       = adr;
    WriteData = wd;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = $urandom;
    for (int k = 1; k <= d + 1; k++) begin
      next_cycle();
      if (k == d) begin
        if (!exp_err && !wr) rd_model = rd;
        checks++;
        if (MemDone !== 1'b1 || MemErr !== exp_err) begin
          errors++;
          $display("FAIL %s_done cyc %0d: MemDone=%b MemErr=%b want 1/%b",
                   name, k, MemDone, MemErr, exp_err);
        end
        checks++;
        if (ReadData !== rd_model) begin
          errors++;
          $display("FAIL %s_rdata: ReadData=%h want %h", name, ReadData, rd_model);
        end
        checks++;
        if (HTRANS !== 2'b00) begin
          errors++;
          $display("FAIL %s_done_htrans: HTRANS=%b want 00", name, HTRANS);
        end
        MemReq = 1'b0;
      end else if (k == d + 1) begin
        checks++;
        if (MemDone !== 1'b0 || MemErr !== 1'b0 || HTRANS !== 2'b00 ||
            ReadData !== rd_model) begin
          errors++;
          $display("FAIL %s_after: D=%b E=%b HTRANS=%b RD=%h want 0/0/00/%h",
                   name, MemDone, MemErr, HTRANS, ReadData, rd_model);
        end
      end else begin
        checks++;
        if (MemDone !== 1'b0 || MemErr !== 1'b0) begin
          errors++;
          $display("FAIL %s_early cyc %0d: MemDone=%b MemErr=%b want 0/0",
                   name, k, MemDone, MemErr);
        end
        if (k <= a_end) begin
          checks++;
          if (HTRANS !== 2'b10 || HADDR !== adr || HWRITE !== wr) begin
            errors++;
            $display("FAIL %s_addr cyc %0d: HTRANS=%b HADDR=%h HWRITE=%b want 10/%h/%b",
                     name, k, HTRANS, HADDR, HWRITE, adr, wr);
          end
        end else begin
          checks++;
          if (HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL %s_data_htrans cyc %0d: HTRANS=%b want 00", name, k, HTRANS);
          end
          if (mode != 1 || k == a_end + 1) begin
            checks++;
            if (HWDATA !== exp_hw) begin
              errors++;
              $display("FAIL %s_hwdata cyc %0d: HWDATA=%h want %h", name, k, HWDATA, exp_hw);
            end
          end
        end
      end
      HRESP  = 1'b0;
      HRDATA = $urandom;
      if (k < d && !mis) begin
        if (k <= a_end) begin
          HREADY = (k == a_end);
        end else if (mode == 0) begin
          HREADY = (k == d - 1);
          if (k == d - 1) HRDATA = rd;
        end else if (mode == 1) begin
          HRESP  = 1'b1;
          HREADY = (k == d - 1);
        end else begin
          HREADY = 1'b0;
        end
      end else begin
        HREADY = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    Adr       = '0;
    WriteData = '0;
    HRDATA    = '0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    rd_model  = '0;
    next_cycle();
    next_cycle();
    check_idle_outputs("reset");
    reset = 1'b1;
  endtask

  task automatic test_zero_wait_read();
    run_xfer("zero_wait_read", 1'b0, 32'h0000_0010, 32'h0, 32'hE3A0_1005, 0, 0, 0);
  endtask

  task automatic test_write_wait();
    run_xfer("write_wait", 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, $urandom, 0, 2, 0);
  endtask

  task automatic test_error();
    run_xfer("error", 1'b0, 32'h0000_0030, 32'h0, $urandom, 0, 0, 1);
  endtask

  task automatic test_misaligned();
    run_xfer("misaligned", 1'b0, 32'h0000_0006, 32'h0, $urandom, 0, 0, 0);
  endtask

  task automatic test_timeout();
    run_xfer("timeout", 1'b0, 32'h0000_0040, 32'h0, $urandom, 0, 0, 2);
  endtask

  task automatic test_wait_boundary();
    run_xfer("wait_boundary", 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678, 2, TO, 0);
  endtask

  task automatic test_reset_mid();
    MemReq    = 1'b1;
    MemWrite  = 1'b1;
    Adr       = 32'h0000_0050;
    WriteData = 32'hCAFE_F00D;
    HREADY    = 1'b0;
    HRESP     = 1'b0;
    next_cycle();
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0050) begin
      errors++;
      $display("FAIL reset_mid_addr: HTRANS=%b HADDR=%h want 10/00000050", HTRANS, HADDR);
    end
    reset = 1'b0;
    next_cycle();
    check_idle_outputs("reset_mid");
    reset    = 1'b1;
    MemReq   = 1'b0;
    HREADY   = 1'b1;
    rd_model = '0;
    run_xfer("after_reset", 1'b0, 32'h0000_0044, 32'h0, $urandom, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] adr;
    int          r;
    int          mode;
    int          dw;
    for (int i = 0; i < 40; i++) begin
      adr = $urandom;
      if ($urandom_range(0, 7) != 0) adr[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r < 6)      mode = 0;
      else if (r < 8) mode = 1;
      else            mode = 2;
      dw = (mode == 0) ? $urandom_range(0, TO) : $urandom_range(0, 2);
      run_xfer("random", 1'($urandom_range(0, 1)), adr, $urandom, $urandom,
               $urandom_range(0, 3), dw, mode);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_error();
    test_misaligned();
    test_timeout();
    test_wait_boundary();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
